// File: rtl/seg_disp_pkg.sv
// Shared constants for the seven-segment display multiplexer: glyph codes (active-low a..g,dp),
// the blank code and the counter width rule.
package seg_disp_pkg;

  localparam logic [7:0] SegBlank = 8'hFF;

  localparam logic [7:0] Glyph0 = 8'h03;
  localparam logic [7:0] Glyph1 = 8'h9F;
  localparam logic [7:0] Glyph2 = 8'h25;
  localparam logic [7:0] Glyph3 = 8'h0D;
  localparam logic [7:0] Glyph4 = 8'h99;
  localparam logic [7:0] Glyph5 = 8'h49;
  localparam logic [7:0] Glyph6 = 8'h41;
  localparam logic [7:0] Glyph7 = 8'h1F;
  localparam logic [7:0] Glyph8 = 8'h01;
  localparam logic [7:0] Glyph9 = 8'h09;
  localparam logic [7:0] GlyphA = 8'h11;
  localparam logic [7:0] GlyphB = 8'hC1;
  localparam logic [7:0] GlyphC = 8'h63;
  localparam logic [7:0] GlyphD = 8'h85;
  localparam logic [7:0] GlyphE = 8'h61;
  localparam logic [7:0] GlyphF = 8'h71;

  // Width of a counter that runs 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational nibble-to-glyph lookup. Hex letters A..F decode only when SEG_HEX_EN is defined;
// otherwise they show blank segments while the decimal point is still honoured.
module seg_decode
  import seg_disp_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dp,
  output logic [7:0] o_seg
);

  logic [7:0] w_glyph;

  always_comb begin
    w_glyph = SegBlank;
    case (i_nibble)
      4'h0:    w_glyph = Glyph0;
      4'h1:    w_glyph = Glyph1;
      4'h2:    w_glyph = Glyph2;
      4'h3:    w_glyph = Glyph3;
      4'h4:    w_glyph = Glyph4;
      4'h5:    w_glyph = Glyph5;
      4'h6:    w_glyph = Glyph6;
      4'h7:    w_glyph = Glyph7;
      4'h8:    w_glyph = Glyph8;
      4'h9:    w_glyph = Glyph9;
`ifdef SEG_HEX_EN
      4'hA:    w_glyph = GlyphA;
      4'hB:    w_glyph = GlyphB;
      4'hC:    w_glyph = GlyphC;
      4'hD:    w_glyph = GlyphD;
      4'hE:    w_glyph = GlyphE;
      4'hF:    w_glyph = GlyphF;
`endif
      default: w_glyph = SegBlank;
    endcase
  end

  // dp is active-low in bit 0
  assign o_seg = {w_glyph[7:1], w_glyph[0] & ~i_dp};

endmodule

// File: rtl/seg_disp_mux.sv
// Multiplexed seven-segment driver with frame-coherent loads, blink and leading-zero blanking.
// Define SEG_HEX_EN to decode nibbles 10..15 as hex letters.
module seg_disp_mux
  import seg_disp_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned SCAN_DIV     = 25000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  lz_blank,
  input  logic                  load,
  output logic [DIGITS-1:0]     dig,
  output logic [7:0]            seg,
  output logic                  frame_done
);

  localparam int unsigned PW = cnt_width(SCAN_DIV);
  localparam int unsigned IW = cnt_width(DIGITS);
  localparam int unsigned FW = cnt_width(BLINK_FRAMES);

  localparam logic [PW-1:0] PrescLast = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IdxLast   = IW'(DIGITS - 1);
  localparam logic [FW-1:0] FcntLast  = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0]       r_presc;
  logic [IW-1:0]       r_idx;
  logic [FW-1:0]       r_fcnt;
  logic                r_phase;
  logic                r_frame_done;

  logic [4*DIGITS-1:0] r_pend_data;
  logic [DIGITS-1:0]   r_pend_dp;
  logic [DIGITS-1:0]   r_pend_blink;
  logic                r_pend_valid;

  logic [4*DIGITS-1:0] r_act_data;
  logic [DIGITS-1:0]   r_act_dp;
  logic [DIGITS-1:0]   r_act_blink;

  logic [DIGITS-1:0]   r_dig;
  logic [7:0]          r_seg;

  logic                w_tick;
  logic                w_boundary;
  logic [DIGITS-1:0]   w_lz_sup;
  logic                w_zero_run;
  logic [3:0]          w_nib;
  logic                w_dp;
  logic                w_blank;
  logic [DIGITS-1:0]   w_dig_nxt;
  logic [7:0]          w_glyph;
  logic [7:0]          w_seg_nxt;

  assign w_tick     = (r_presc == PrescLast);
  assign w_boundary = w_tick && (r_idx == IdxLast);

  // Scan timing: prescaler, digit index and end-of-frame pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_presc      <= w_tick ? '0 : r_presc + PW'(1);
      r_frame_done <= w_boundary;
      if (w_tick) begin
        r_idx <= (r_idx == IdxLast) ? '0 : r_idx + IW'(1);
      end
    end
  end

  // Loads land in pending and are promoted only at a frame boundary, so a frame never tears.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend_data  <= '0;
      r_pend_dp    <= '0;
      r_pend_blink <= '0;
      r_pend_valid <= 1'b0;
      r_act_data   <= '0;
      r_act_dp     <= '0;
      r_act_blink  <= '0;
    end else begin
      if (load) begin
        r_pend_data  <= data_in;
        r_pend_dp    <= dp_in;
        r_pend_blink <= blink_mask;
      end
      if (w_boundary) begin
        if (load) begin
          r_act_data  <= data_in;
          r_act_dp    <= dp_in;
          r_act_blink <= blink_mask;
        end else if (r_pend_valid) begin
          r_act_data  <= r_pend_data;
          r_act_dp    <= r_pend_dp;
          r_act_blink <= r_pend_blink;
        end
        r_pend_valid <= 1'b0;
      end else if (load) begin
        r_pend_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fcnt  <= '0;
      r_phase <= 1'b0;
    end else if (w_boundary) begin
      if (r_fcnt == FcntLast) begin
        r_fcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_fcnt <= r_fcnt + FW'(1);
      end
    end
  end

  // A zero run from the top digit downward is suppressed; dp rescues only its own digit.
  always_comb begin
    w_lz_sup   = '0;
    w_zero_run = lz_blank;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      w_zero_run  = w_zero_run && (r_act_data[4*k +: 4] == 4'h0);
      w_lz_sup[k] = w_zero_run && !r_act_dp[k];
    end
  end

  always_comb begin
    w_nib     = '0;
    w_dp      = 1'b0;
    w_blank   = 1'b0;
    w_dig_nxt = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_idx == IW'(k)) begin
        w_nib        = r_act_data[4*k +: 4];
        w_dp         = r_act_dp[k];
        w_blank      = w_lz_sup[k] || (r_phase && r_act_blink[k]);
        w_dig_nxt[k] = 1'b0;
      end
    end
    if (w_blank) begin
      w_dig_nxt = '1;
    end
  end

  seg_decode u_seg_decode (
    .i_nibble (w_nib),
    .i_dp     (w_dp),
    .o_seg    (w_glyph)
  );

  assign w_seg_nxt = w_blank ? SegBlank : w_glyph;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dig <= '1;
      r_seg <= SegBlank;
    end else begin
      r_dig <= w_dig_nxt;
      r_seg <= w_seg_nxt;
    end
  end

  assign dig        = r_dig;
  assign seg        = r_seg;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_disp_mux.sv
// Directed bench for seg_disp_mux at DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
module tb_seg_disp_mux;

  logic        clk;
  logic        rst_n;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  blink_mask;
  logic        lz_blank;
  logic        load;
  logic [3:0]  dig;
  logic [7:0]  seg;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;  // rising edges since reset release

  seg_disp_mux #(
    .DIGITS       (4),
    .SCAN_DIV     (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .blink_mask (blink_mask),
    .lz_blank   (lz_blank),
    .load       (load),
    .dig        (dig),
    .seg        (seg),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic        lz;
    logic [3:0]  dark;
    logic [31:0] segs;  // {d3,d2,d1,d0}
  } vec_t;

  vec_t tbl [11];

  function automatic logic [7:0] hx(input logic [7:0] g);
`ifdef SEG_HEX_EN
    return g;
`else
    return 8'hFF;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_disp(input string name, input logic [3:0] edig, input logic [7:0] eseg);
    check(name, {20'h0, dig, seg}, {20'h0, edig, eseg});
  endtask

  task automatic wait_cyc(input int t);
    if (cyc > t) begin
      errors++;
      $display("FAIL schedule: got cycle %0d expected at most %0d", cyc, t);
    end
    while (cyc < t) @(negedge clk);
  endtask

  task automatic load_vec(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bm,
                          input logic lz);
    data_in    = d;
    dp_in      = dp;
    blink_mask = bm;
    lz_blank   = lz;
    load       = 1'b1;
    @(negedge clk);
    load       = 1'b0;
  endtask

  function automatic logic [3:0] onehot_low(input int d);
    logic [3:0] v;
    v = 4'b0001 << d;
    return ~v;
  endfunction

  initial begin
    tbl[0]  = '{16'h0070, 4'b0000, 1'b1, 4'b1100, {8'hFF, 8'hFF, 8'h1F, 8'h03}};
    tbl[1]  = '{16'h0070, 4'b1000, 1'b1, 4'b0100, {8'h02, 8'hFF, 8'h1F, 8'h03}};
    tbl[2]  = '{16'h0000, 4'b0000, 1'b1, 4'b1110, {8'hFF, 8'hFF, 8'hFF, 8'h03}};
    tbl[3]  = '{16'h0000, 4'b0000, 1'b0, 4'b0000, {8'h03, 8'h03, 8'h03, 8'h03}};
    tbl[4]  = '{16'h1005, 4'b0000, 1'b1, 4'b0000, {8'h9F, 8'h03, 8'h03, 8'h49}};
    tbl[5]  = '{16'h9A82, 4'b0010, 1'b0, 4'b0000, {8'h09, hx(8'h11), 8'h00, 8'h25}};
    tbl[6]  = '{16'h0A00, 4'b0100, 1'b1, 4'b1000, {8'hFF, hx(8'h11) & 8'hFE, 8'h03, 8'h03}};
    tbl[7]  = '{16'h6034, 4'b0001, 1'b1, 4'b0000, {8'h41, 8'h03, 8'h0D, 8'h98}};
    tbl[8]  = '{16'h0BCD, 4'b0000, 1'b1, 4'b1000, {8'hFF, hx(8'hC1), hx(8'h63), hx(8'h85)}};
    tbl[9]  = '{16'hEF00, 4'b0000, 1'b0, 4'b0000, {hx(8'h61), hx(8'h71), 8'h03, 8'h03}};
    tbl[10] = '{16'h0000, 4'b0100, 1'b1, 4'b1010, {8'hFF, 8'h02, 8'hFF, 8'h03}};

    rst_n      = 1'b0;
    data_in    = 16'h0;
    dp_in      = 4'h0;
    blink_mask = 4'h0;
    lz_blank   = 1'b0;
    load       = 1'b0;
    repeat (3) @(negedge clk);
    check_disp("reset_disp", 4'b1111, 8'hFF);
    check("reset_frame_done", {31'h0, frame_done}, 32'h0);
    rst_n = 1'b1;

    // Reset release and scan timing
    wait_cyc(1);  check_disp("first_digit", 4'b1110, 8'h03);
    wait_cyc(6);  check_disp("f0_d1", 4'b1101, 8'h03);
    wait_cyc(15); check("fd_c15", {31'h0, frame_done}, 32'h0);
    wait_cyc(16); check("fd_c16", {31'h0, frame_done}, 32'h1);
    wait_cyc(17); check("fd_c17", {31'h0, frame_done}, 32'h0);

    // Mid-frame load is held until the boundary
    wait_cyc(21); load_vec(16'h1234, 4'h0, 4'h0, 1'b0);
    wait_cyc(26); check_disp("hold_d2", 4'b1011, 8'h03);
    wait_cyc(30); check_disp("hold_d3", 4'b0111, 8'h03);
    wait_cyc(31); check("fd_c31", {31'h0, frame_done}, 32'h0);
    wait_cyc(32); check("fd_c32", {31'h0, frame_done}, 32'h1);
    wait_cyc(34); check_disp("new_d0", 4'b1110, 8'h99);
    wait_cyc(38); check_disp("new_d1", 4'b1101, 8'h0D);
    wait_cyc(42); check_disp("new_d2", 4'b1011, 8'h25);
    wait_cyc(46); check_disp("new_d3", 4'b0111, 8'h9F);

    // Load on the boundary goes straight to the next frame; last of several loads wins
    wait_cyc(47); load_vec(16'h5678, 4'h0, 4'h0, 1'b0);
    wait_cyc(50); check_disp("coin_d0", 4'b1110, 8'h01);
    wait_cyc(52); load_vec(16'h1111, 4'h0, 4'h0, 1'b0);
    wait_cyc(56); load_vec(16'h0987, 4'h0, 4'h0, 1'b0);
    wait_cyc(58); check_disp("coin_d2", 4'b1011, 8'h41);
    wait_cyc(62); check_disp("coin_d3", 4'b0111, 8'h49);
    wait_cyc(66); check_disp("last_d0", 4'b1110, 8'h1F);
    wait_cyc(70); check_disp("last_d1", 4'b1101, 8'h01);
    wait_cyc(74); check_disp("last_d2", 4'b1011, 8'h09);
    wait_cyc(78); check_disp("last_d3", 4'b0111, 8'h03);

    // Table: load late in frame F, inspect all digits of frame F+1
    for (int i = 0; i < 11; i++) begin
      int f;
      f = 4 + i;
      wait_cyc(16 * f + 14);
      load_vec(tbl[i].data, tbl[i].dp, 4'h0, tbl[i].lz);
      for (int d = 0; d < 4; d++) begin
        logic [3:0] edig;
        logic [7:0] eseg;
        edig = tbl[i].dark[d] ? 4'b1111 : onehot_low(d);
        eseg = tbl[i].dark[d] ? 8'hFF : tbl[i].segs[8*d +: 8];
        wait_cyc(16 * (f + 1) + 4 * d + 2);
        check_disp($sformatf("tbl%0d_d%0d", i, d), edig, eseg);
      end
    end

    // Reset mid-frame with a pending load and a load in flight
    wait_cyc(261);
    load_vec(16'h8888, 4'h0, 4'h0, 1'b0);
    rst_n   = 1'b0;
    data_in = 16'h4444;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
    data_in = 16'h0;
    lz_blank = 1'b0;
    check_disp("midreset_disp", 4'b1111, 8'hFF);
    check("midreset_fd", {31'h0, frame_done}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(1);  check_disp("rel_first_digit", 4'b1110, 8'h03);
    wait_cyc(14); check_disp("rel_f0_d3", 4'b0111, 8'h03);
    wait_cyc(18); check_disp("rel_f1_d0_discard", 4'b1110, 8'h03);

    // Blink on digit 0: dark in frames 2-3 and 6-7
    wait_cyc(21); load_vec(16'h0012, 4'h0, 4'b0001, 1'b0);
    for (int f = 2; f <= 8; f++) begin
      logic dark;
      dark = (f == 2) || (f == 3) || (f == 6) || (f == 7);
      wait_cyc(16 * f + 2);
      check_disp($sformatf("blink_f%0d_d0", f), dark ? 4'b1111 : 4'b1110,
                 dark ? 8'hFF : 8'h25);
      if (f == 2) begin
        wait_cyc(16 * f + 6);
        check_disp("blink_f2_d1", 4'b1101, 8'h9F);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
